// File: rtl/sample_capture.sv
// rtl/sample_capture.sv - codec ADC sample capture: frame edge detect, decimation, FWFT FIFO, overflow tracking
module sample_capture #(
   parameter int DEPTH    = 8,
   parameter int ADDR_W   = 3,
   parameter int DECIMATE = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              new_frame,
   input  logic [15:0]       adc_sample_in,
   input  logic              capture_en,
   input  logic              flush,
   input  logic              clear_overflow,
   input  logic              sample_ready,
   output logic              sample_valid,
   output logic [15:0]       sample_out,
   output logic [ADDR_W:0]   level,
   output logic              overflow,
   output logic [7:0]        overflow_count,
   output logic              frame_tick
);

   localparam logic [7:0]      DEC_LAST = 8'(DECIMATE - 1);
   localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W + 1)'(1);

   logic [15:0]     mem_q [DEPTH];
   logic            nf_q, nf_d;
   logic            frame_tick_q, frame_tick_d;
   logic [7:0]      dec_cnt_q, dec_cnt_d;
   logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
   logic            overflow_q, overflow_d;
   logic [7:0]      ovf_cnt_q, ovf_cnt_d;
   logic [15:0]     sample_out_q, sample_out_d;

   logic tick, wr_req, empty, full, pop, do_write, drop;

   always_comb begin
      nf_d         = new_frame;
      tick         = new_frame & ~nf_q;
      frame_tick_d = tick;

      dec_cnt_d = dec_cnt_q;
      if (!capture_en)
         dec_cnt_d = '0;
      else if (tick)
         dec_cnt_d = (dec_cnt_q == DEC_LAST) ? 8'd0 : dec_cnt_q + 8'd1;

      wr_req = tick & capture_en & (dec_cnt_q == 8'd0);
      empty  = (wr_ptr_q == rd_ptr_q);
      full   = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
               (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
      pop    = ~empty & sample_ready;

      do_write = 1'b0;
      drop     = 1'b0;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         rd_ptr_d = wr_ptr_q;
      end else begin
         do_write = wr_req & (~full | pop);
         drop     = wr_req & full & ~pop;
         if (do_write)
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (pop)
            rd_ptr_d = rd_ptr_q + PTR_ONE;
      end

      // A drop in the same cycle as clear_overflow still records itself.
      overflow_d = overflow_q;
      ovf_cnt_d  = ovf_cnt_q;
      if (drop) begin
         overflow_d = 1'b1;
         if (clear_overflow)
            ovf_cnt_d = 8'd1;
         else if (ovf_cnt_q != 8'hFF)
            ovf_cnt_d = ovf_cnt_q + 8'd1;
      end else if (clear_overflow) begin
         overflow_d = 1'b0;
         ovf_cnt_d  = 8'd0;
      end

      // Head register: bypass the incoming sample when it lands on an empty FIFO.
      sample_out_d = sample_out_q;
      if (rd_ptr_d != wr_ptr_d) begin
         if (do_write && (rd_ptr_d == wr_ptr_q))
            sample_out_d = adc_sample_in;
         else
            sample_out_d = mem_q[rd_ptr_d[ADDR_W-1:0]];
      end
   end

   always_ff @(posedge clk) begin
      if (do_write)
         mem_q[wr_ptr_q[ADDR_W-1:0]] <= adc_sample_in;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         nf_q         <= 1'b0;
         frame_tick_q <= 1'b0;
         dec_cnt_q    <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         overflow_q   <= 1'b0;
         ovf_cnt_q    <= '0;
         sample_out_q <= '0;
      end else begin
         nf_q         <= nf_d;
         frame_tick_q <= frame_tick_d;
         dec_cnt_q    <= dec_cnt_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         overflow_q   <= overflow_d;
         ovf_cnt_q    <= ovf_cnt_d;
         sample_out_q <= sample_out_d;
      end
   end

   assign sample_valid   = (wr_ptr_q != rd_ptr_q);
   assign sample_out     = sample_out_q;
   assign level          = wr_ptr_q - rd_ptr_q;
   assign overflow       = overflow_q;
   assign overflow_count = ovf_cnt_q;
   assign frame_tick     = frame_tick_q;

endmodule
